// File: rtl/icache_assoc_pkg.sv
// Shared constants for the set-associative instruction cache: miss FSM encodings and way-index sizing.
package icache_assoc_pkg;

    typedef logic [31:0] word_t;

    localparam logic [1:0] IC_IDLE  = 2'd0;
    localparam logic [1:0] IC_MISS  = 2'd1;
    localparam logic [1:0] IC_DRAIN = 2'd2;

    // Width of a way number; a direct-mapped cache still carries one bit.
    function automatic int ic_way_w(input int ways);
        return (ways <= 2) ? 1 : $clog2(ways);
    endfunction

endpackage

// File: rtl/icache_assoc_way.sv
// One way of the instruction cache: per-set valid/tag/data storage with a combinational
// lookup port and a single fill port; valid bits are flops so fence.i can clear them at once.
module icache_way
    import icache_assoc_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             hit_o,
    output logic [31:0]      data_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i,
    input  logic             inv_all_i,
    output logic             wr_valid_o
);
    localparam int SETS = 1 << IDX_W;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_mem  [SETS];
    word_t            data_mem [SETS];

    // Invalidate takes priority over a coincident fill's valid bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (inv_all_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_mem[wr_idx_i]  <= wr_tag_i;
            data_mem[wr_idx_i] <= wr_data_i;
        end
    end

    assign hit_o      = valid_q[rd_idx_i] && (tag_mem[rd_idx_i] == rd_tag_i);
    assign data_o     = data_mem[rd_idx_i];
    assign wr_valid_o = valid_q[wr_idx_i];

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache between IF and MemCtrl: one-cycle hits,
// a MISS/DRAIN fill FSM, per-set round-robin replacement, flush and fence.i support.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int WAYS  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        inv_all,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        ins_valid,
    output logic [31:0] ins_out,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_done,
    input  logic [31:0] mc_data
);
    localparam int SETS  = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;
    localparam int WAY_W = ic_way_w(WAYS);

    logic [1:0]  state_q, state_d;
    logic        ins_valid_q, ins_valid_d;
    word_t       ins_out_q, ins_out_d;
    logic        mc_req_q, mc_req_d;
    word_t       mc_addr_q, mc_addr_d;
    logic [WAY_W-1:0] rr_q [SETS];

    logic [IDX_W-1:0] lk_idx, fill_idx;
    logic [TAG_W-1:0] lk_tag, fill_tag;
    logic [WAYS-1:0]  way_hit, way_we, way_wr_valid;
    word_t            way_data [WAYS];
    logic             any_hit;
    word_t            hit_data;
    logic             fill_en;
    logic [WAY_W-1:0] victim, rr_next;
    logic             unused_bits;

    // Lookups use the live pc; fills use the address latched at miss time, since IF may move on after a flush.
    assign lk_idx   = if_pc[IDX_W+1:2];
    assign lk_tag   = if_pc[31:IDX_W+2];
    assign fill_idx = mc_addr_q[IDX_W+1:2];
    assign fill_tag = mc_addr_q[31:IDX_W+2];
    assign fill_en  = rdy && (state_q != IC_IDLE) && mc_done;
    assign unused_bits = ^{if_pc[1:0], mc_addr_q[1:0]};

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign way_we[gi] = fill_en && (victim == WAY_W'(gi));
            icache_way #(
                .IDX_W(IDX_W),
                .TAG_W(TAG_W)
            ) u_way (
                .clk        (clk),
                .rst        (rst),
                .rd_idx_i   (lk_idx),
                .rd_tag_i   (lk_tag),
                .hit_o      (way_hit[gi]),
                .data_o     (way_data[gi]),
                .we_i       (way_we[gi]),
                .wr_idx_i   (fill_idx),
                .wr_tag_i   (fill_tag),
                .wr_data_i  (mc_data),
                .inv_all_i  (inv_all && rdy),
                .wr_valid_o (way_wr_valid[gi])
            );
        end
    endgenerate

    // At most one way matches, so OR-ing the gated data is a valid mux.
    always_comb begin
        any_hit  = 1'b0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                any_hit  = 1'b1;
                hit_data = hit_data | way_data[w];
            end
        end
    end

    // Scanning downwards leaves the lowest-numbered invalid way as victim.
    always_comb begin
        victim = rr_q[fill_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_wr_valid[w]) begin
                victim = WAY_W'(w);
            end
        end
        rr_next = (victim == WAY_W'(WAYS - 1)) ? '0 : victim + 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        ins_valid_d = 1'b0;
        ins_out_d   = ins_out_q;
        mc_req_d    = mc_req_q;
        mc_addr_d   = mc_addr_q;
        case (state_q)
            IC_IDLE: begin
                // IF still presents the delivered pc during the ins_valid cycle; skip it to avoid a double delivery.
                if (if_valid && !flush && !ins_valid_q) begin
                    if (any_hit) begin
                        ins_out_d   = hit_data;
                        ins_valid_d = 1'b1;
                    end else begin
                        mc_req_d  = 1'b1;
                        mc_addr_d = {if_pc[31:2], 2'b00};
                        state_d   = IC_MISS;
                    end
                end
            end
            IC_MISS: begin
                if (mc_done) begin
                    mc_req_d    = 1'b0;
                    ins_out_d   = mc_data;
                    ins_valid_d = !flush;
                    state_d     = IC_IDLE;
                end else if (flush) begin
                    state_d = IC_DRAIN;
                end
            end
            IC_DRAIN: begin
                if (mc_done) begin
                    mc_req_d = 1'b0;
                    state_d  = IC_IDLE;
                end
            end
            default: state_d = IC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IC_IDLE;
            ins_valid_q <= 1'b0;
            ins_out_q   <= '0;
            mc_req_q    <= 1'b0;
            mc_addr_q   <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            ins_valid_q <= ins_valid_d;
            ins_out_q   <= ins_out_d;
            mc_req_q    <= mc_req_d;
            mc_addr_q   <= mc_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else if (fill_en) begin
            rr_q[fill_idx] <= rr_next;
        end
    end

    assign ins_valid = ins_valid_q;
    assign ins_out   = ins_out_q;
    assign mc_req    = mc_req_q;
    assign mc_addr   = mc_addr_q;

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: a MemCtrl responder model plus a scoreboard of expected instructions.
module tb_icache_assoc;
    localparam int MC_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        inv_all = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic        ins_valid;
    logic [31:0] ins_out;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_done = 1'b0;
    logic [31:0] mc_data = '0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb_q[$];

    bit          mc_busy = 1'b0;
    int          mc_cnt = 0;
    int          mc_reqs = 0;
    logic [31:0] mc_addr_seen = '0;
    bit          inv_on_done = 1'b0;

    icache_assoc dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .inv_all   (inv_all),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .ins_valid (ins_valid),
        .ins_out   (ins_out),
        .mc_req    (mc_req),
        .mc_addr   (mc_addr),
        .mc_done   (mc_done),
        .mc_data   (mc_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0000_0013;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // MemCtrl model: answers a request MC_LAT active cycles after first seeing it; stalls while rdy is low.
    always @(negedge clk) begin
        mc_done = 1'b0;
        inv_all = 1'b0;
        if (!rst && rdy) begin
            if (mc_busy) begin
                if (mc_cnt == 0) begin
                    mc_done = 1'b1;
                    mc_data = mem_word(mc_addr_seen);
                    inv_all = inv_on_done;
                    mc_busy = 1'b0;
                end else begin
                    mc_cnt--;
                end
            end else if (mc_req) begin
                mc_busy      = 1'b1;
                mc_cnt       = MC_LAT - 1;
                mc_addr_seen = mc_addr;
                mc_reqs++;
            end
        end
    end

    task automatic fetch(input logic [31:0] pc, input bit exp_hit, input string tag);
        int base;
        int cyc;
        logic [31:0] aligned;
        aligned = {pc[31:2], 2'b00};
        base = mc_reqs;
        @(negedge clk);
        if_valid = 1'b1;
        if_pc    = pc;
        sb_q.push_back(mem_word(pc));
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ins_valid !== 1'b1 && cyc < 40);
        if_valid = 1'b0;
        check({tag, " valid"}, {31'b0, ins_valid}, 32'd1);
        check({tag, " data"}, ins_out, sb_q.pop_front());
        check({tag, " latency"}, 32'(cyc), exp_hit ? 32'd1 : 32'(MC_LAT + 2));
        check({tag, " mc_reqs"}, 32'(mc_reqs - base), exp_hit ? 32'd0 : 32'd1);
        if (!exp_hit) check({tag, " mc_addr"}, mc_addr_seen, aligned);
    endtask

    initial begin
        int base;
        int seen;
        int cyc;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset ins_valid", {31'b0, ins_valid}, 32'd0);
        check("reset ins_out", ins_out, 32'd0);
        check("reset mc_req", {31'b0, mc_req}, 32'd0);
        check("reset mc_addr", mc_addr, 32'd0);

        fetch(32'h100, 1'b0, "cold 100");
        fetch(32'h100, 1'b1, "hit 100");

        // Three lines in set 0 of a 2-way cache: round-robin evicts 0x100.
        fetch(32'h200, 1'b0, "fill 200");
        fetch(32'h300, 1'b0, "fill 300");
        fetch(32'h200, 1'b1, "hit 200");
        fetch(32'h100, 1'b0, "evicted 100");
        fetch(32'h300, 1'b1, "hit 300");

        // Flush one cycle after mc_req rises: fetch drains silently, line still filled.
        base = mc_reqs;
        @(negedge clk);
        if_valid = 1'b1;
        if_pc    = 32'h400;
        @(negedge clk);
        check("drain req", {31'b0, mc_req}, 32'd1);
        flush    = 1'b1;
        if_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check("drain hold1", {31'b0, mc_req}, 32'd1);
        @(negedge clk);
        check("drain hold2", {31'b0, mc_req}, 32'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ins_valid === 1'b1) seen++;
        end
        check("drain no ins_valid", 32'(seen), 32'd0);
        check("drain mc_req low", {31'b0, mc_req}, 32'd0);
        check("drain reqs", 32'(mc_reqs - base), 32'd1);
        fetch(32'h400, 1'b1, "hit after drain");

        // Flush alongside a would-be hit suppresses it.
        base = mc_reqs;
        @(negedge clk);
        if_valid = 1'b1;
        if_pc    = 32'h400;
        flush    = 1'b1;
        @(negedge clk);
        check("flush hit ins_valid", {31'b0, ins_valid}, 32'd0);
        check("flush hit mc_req", {31'b0, mc_req}, 32'd0);
        flush    = 1'b0;
        if_valid = 1'b0;

        // rdy low for five cycles in MISS.
        @(negedge clk);
        if_valid = 1'b1;
        if_pc    = 32'h104;
        sb_q.push_back(mem_word(32'h104));
        @(negedge clk);
        check("stall req", {31'b0, mc_req}, 32'd1);
        @(posedge clk);
        #1 rdy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall mc_req", {31'b0, mc_req}, 32'd1);
            check("stall mc_addr", mc_addr, 32'h104);
            check("stall ins_valid", {31'b0, ins_valid}, 32'd0);
        end
        @(posedge clk);
        #1 rdy = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (ins_valid !== 1'b1 && cyc < 40);
        if_valid = 1'b0;
        check("stall valid", {31'b0, ins_valid}, 32'd1);
        check("stall data", ins_out, sb_q.pop_front());
        fetch(32'h104, 1'b1, "hit 104");

        // Invalidate coincident with the fill: data delivered, line not kept; everything else cleared too.
        inv_on_done = 1'b1;
        fetch(32'h500, 1'b0, "inv fill 500");
        inv_on_done = 1'b0;
        fetch(32'h500, 1'b0, "refetch 500");
        fetch(32'h104, 1'b0, "cleared 104");
        fetch(32'h500, 1'b1, "hit 500");

        fetch(32'hFFFF_FFFC, 1'b0, "wrap miss");
        fetch(32'hFFFF_FFFC, 1'b1, "wrap hit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
